pixel_line_fifo: RTL and testbench

PIXEL_LINE_FIFO -- requirements
Module: pixel_line_fifo

---
 rtl/pixel_fifo_pkg.sv | 22 ++
 rtl/pixel_fifo_ram.sv | 26 ++
 rtl/pixel_line_fifo.sv | 122 ++++++++++++
 tb/tb_pixel_line_fifo.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/pixel_fifo_pkg.sv
// Shared defaults and pixel field layout for the pixel line FIFO.
package pixel_fifo_pkg;

    localparam int unsigned DATA_W_DEF     = 32;
    localparam int unsigned DEPTH_LOG2_DEF = 9;
    localparam int unsigned HALF_LEVEL_DEF = 256;

    localparam int unsigned PIX_R_MSB = 31;
    localparam int unsigned PIX_R_LSB = 24;
    localparam int unsigned PIX_G_MSB = 23;
    localparam int unsigned PIX_G_LSB = 16;
    localparam int unsigned PIX_B_MSB = 15;
    localparam int unsigned PIX_B_LSB = 8;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic [7:0] pad;
    } pixel_t;

endpackage

// File: rtl/pixel_fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read.
module pixel_fifo_ram
    import pixel_fifo_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = DEPTH_LOG2_DEF
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/pixel_line_fifo.sv
// First-word-fall-through pixel line FIFO between DDR burst reads and the HDMI core.
// Optional underflow pop counter enabled by PIXEL_FIFO_UNDERFLOW_CNT_EN.
module pixel_line_fifo
    import pixel_fifo_pkg::*;
#(
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF,
    parameter int unsigned HALF_LEVEL = HALF_LEVEL_DEF
) (
    input  logic                  Bus2IP_Clk,
    input  logic                  Bus2IP_Reset,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_W-1:0]     wr_data,
    output logic                  full,
    input  logic                  rd_en,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  empty,
    output logic                  half_full,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    output logic                  underflow,
    output logic [15:0]           underflow_cnt
);

    localparam int unsigned PW = DEPTH_LOG2 + 1;
    localparam logic [PW-1:0] HALF_THR = PW'(HALF_LEVEL);

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     level_q, level_d;
    logic              full_q, full_d, empty_q, empty_d, half_q, half_d;
    logic              ovf_q, ovf_d, udf_q, udf_d;
    logic [DATA_W-1:0] hold_q, hold_d, ram_rd_data;
    logic              wr_acc, rd_acc, udf_event;

    always_comb begin
        wr_acc    = wr_en && !full_q && !flush;
        rd_acc    = rd_en && !empty_q && !flush;
        udf_event = rd_en && empty_q && !flush;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + PW'(1);
            if (rd_acc) rd_ptr_d = rd_ptr_q + PW'(1);
        end
        ovf_d   = ovf_q || (wr_en && full_q && !flush);
        udf_d   = udf_q || udf_event;
        // Keep the word being popped so rd_data stays stable once the FIFO runs dry.
        hold_d  = rd_acc ? ram_rd_data : hold_q;
        level_d = wr_ptr_d - rd_ptr_d;
        full_d  = (wr_ptr_d[PW-1] != rd_ptr_d[PW-1]) &&
                  (wr_ptr_d[PW-2:0] == rd_ptr_d[PW-2:0]);
        empty_d = (wr_ptr_d == rd_ptr_d);
        half_d  = (level_d >= HALF_THR);
    end

    always_ff @(posedge Bus2IP_Clk) begin
        if (Bus2IP_Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            half_q   <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            hold_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            half_q   <= half_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            hold_q   <= hold_d;
        end
    end

    pixel_fifo_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (DEPTH_LOG2)
    ) u_ram (
        .clk   (Bus2IP_Clk),
        .we    (wr_acc && !Bus2IP_Reset),
        .waddr (wr_ptr_q[PW-2:0]),
        .wdata (wr_data),
        .raddr (rd_ptr_q[PW-2:0]),
        .rdata (ram_rd_data)
    );

`ifdef PIXEL_FIFO_UNDERFLOW_CNT_EN
    logic [15:0] ucnt_q, ucnt_d;

    always_comb begin
        ucnt_d = ucnt_q;
        if (udf_event && (ucnt_q != 16'hFFFF)) ucnt_d = ucnt_q + 16'd1;
    end

    always_ff @(posedge Bus2IP_Clk) begin
        if (Bus2IP_Reset) ucnt_q <= '0;
        else              ucnt_q <= ucnt_d;
    end

    assign underflow_cnt = ucnt_q;
`else
    assign underflow_cnt = '0;
`endif

    assign rd_data   = empty_q ? hold_q : ram_rd_data;
    assign full      = full_q;
    assign empty     = empty_q;
    assign half_full = half_q;
    assign level     = level_q;
    assign overflow  = ovf_q;
    assign underflow = udf_q;

endmodule

// File: tb/tb_pixel_line_fifo.sv
// Directed/randomized bench for pixel_line_fifo against a queue-based reference model.
module tb_pixel_line_fifo;

    localparam int unsigned DEPTH = 512;

    logic        Bus2IP_Clk = 1'b0;
    logic        Bus2IP_Reset = 1'b1;
    logic        flush = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] wr_data = '0;
    logic        full;
    logic        rd_en = 1'b0;
    logic [31:0] rd_data;
    logic        empty;
    logic        half_full;
    logic [9:0]  level;
    logic        overflow;
    logic        underflow;
    logic [15:0] underflow_cnt;

    pixel_line_fifo #(
        .DATA_W     (32),
        .DEPTH_LOG2 (9),
        .HALF_LEVEL (256)
    ) dut (
        .Bus2IP_Clk    (Bus2IP_Clk),
        .Bus2IP_Reset  (Bus2IP_Reset),
        .flush         (flush),
        .wr_en         (wr_en),
        .wr_data       (wr_data),
        .full          (full),
        .rd_en         (rd_en),
        .rd_data       (rd_data),
        .empty         (empty),
        .half_full     (half_full),
        .level         (level),
        .overflow      (overflow),
        .underflow     (underflow),
        .underflow_cnt (underflow_cnt)
    );

    always #5 Bus2IP_Clk = ~Bus2IP_Clk;

    // Reference model: contents as a queue plus sticky status.
    logic [31:0] q[$];
    logic [31:0] m_last;
    bit          m_ovf, m_udf;
    int unsigned m_ucnt;
    int unsigned n_assert = 0;
    int unsigned n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] exp_rd;
        logic [31:0] exp_cnt;
        exp_rd = (q.size() != 0) ? q[0] : m_last;
`ifdef PIXEL_FIFO_UNDERFLOW_CNT_EN
        exp_cnt = m_ucnt;
`else
        exp_cnt = 0;
`endif
        chk({tag, ".level"},     32'(level),         q.size());
        chk({tag, ".empty"},     32'(empty),         32'(q.size() == 0));
        chk({tag, ".full"},      32'(full),          32'(q.size() == DEPTH));
        chk({tag, ".half_full"}, 32'(half_full),     32'(q.size() >= 256));
        chk({tag, ".rd_data"},   rd_data,            exp_rd);
        chk({tag, ".overflow"},  32'(overflow),      32'(m_ovf));
        chk({tag, ".underflow"}, 32'(underflow),     32'(m_udf));
        chk({tag, ".ucnt"},      32'(underflow_cnt), exp_cnt);
    endtask

    task automatic do_reset();
        Bus2IP_Reset = 1'b1;
        wr_en = 1'b1;
        rd_en = 1'b1;
        flush = 1'b1;
        wr_data = $urandom;
        repeat (2) @(posedge Bus2IP_Clk);
        #1;
        Bus2IP_Reset = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        flush = 1'b0;
        q.delete();
        m_last = '0;
        m_ovf = 1'b0;
        m_udf = 1'b0;
        m_ucnt = 0;
        check_all("reset");
    endtask

    task automatic step(input string tag, input bit we, input logic [31:0] wd,
                        input bit re, input bit fl);
        bit was_full, was_empty;
        wr_en = we;
        wr_data = wd;
        rd_en = re;
        flush = fl;
        was_full = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        @(posedge Bus2IP_Clk);
        #1;
        if (fl) begin
            q.delete();
        end else begin
            if (re) begin
                if (was_empty) begin
                    m_udf = 1'b1;
                    if (m_ucnt != 16'hFFFF) m_ucnt++;
                end else begin
                    m_last = q.pop_front();
                end
            end
            if (we) begin
                if (was_full) m_ovf = 1'b1;
                else q.push_back(wd);
            end
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        flush = 1'b0;
        check_all(tag);
    endtask

    initial begin
        int unsigned writes;
        logic [31:0] w;

        #1;
        do_reset();

        // Two back-to-back writes into an empty FIFO.
        step("wr0", 1'b1, 32'h80808000, 1'b0, 1'b0);
        chk("wr0.empty_now_low", 32'(empty), 32'd0);
        step("wr1", 1'b1, 32'h80808100, 1'b0, 1'b0);
        chk("wr1.head", rd_data, 32'h80808000);
        chk("wr1.level2", 32'(level), 32'd2);
        step("pop0", 1'b0, 32'h0, 1'b1, 1'b0);
        step("pop1", 1'b0, 32'h0, 1'b1, 1'b0);

        // Fill to full, then a write alongside a pop is dropped.
        do_reset();
        for (int i = 0; i < 512; i++) step("fill", 1'b1, $urandom, 1'b0, 1'b0);
        chk("fill.full", 32'(full), 32'd1);
        step("ovf", 1'b1, $urandom, 1'b1, 1'b0);
        chk("ovf.flag", 32'(overflow), 32'd1);
        chk("ovf.level511", 32'(level), 32'd511);

        // Steady state at 300 with concurrent write and pop.
        for (int i = 0; i < 211; i++) step("drain300", 1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 100; i++) step("steady", 1'b1, $urandom, 1'b1, 1'b0);
        chk("steady.level300", 32'(level), 32'd300);

        // Flush at level 200 wins over write and pop.
        for (int i = 0; i < 100; i++) step("drain200", 1'b0, 32'h0, 1'b1, 1'b0);
        step("flush", 1'b1, $urandom, 1'b1, 1'b1);
        chk("flush.level0", 32'(level), 32'd0);
        chk("flush.empty", 32'(empty), 32'd1);
        w = $urandom;
        step("post_flush_wr", 1'b1, w, 1'b0, 1'b0);
        chk("post_flush.head", rd_data, w);

        // Underflow after draining: rd_data holds the last popped word.
        step("pop_last", 1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step("udf", 1'b0, 32'h0, 1'b1, 1'b0);
        chk("udf.hold", rd_data, w);
`ifdef PIXEL_FIFO_UNDERFLOW_CNT_EN
        chk("udf.cnt3", 32'(underflow_cnt), 32'd3);
`else
        chk("udf.cnt0", 32'(underflow_cnt), 32'd0);
`endif

        // Pointer wrap with occupancy kept in 1..10.
        do_reset();
        writes = 0;
        while (writes < 1000) begin
            bit we, re;
            if (q.size() <= 1) begin
                we = 1'b1;
                re = 1'b0;
            end else if (q.size() >= 10) begin
                we = 1'b0;
                re = 1'b1;
            end else begin
                we = ($urandom_range(0, 1) == 1);
                re = ($urandom_range(0, 1) == 1);
            end
            if (we) writes++;
            step("wrap", we, $urandom, re, 1'b0);
        end

        // Reset in the middle of a burst discards content.
        for (int i = 0; i < 5; i++) step("burst", 1'b1, $urandom, 1'b0, 1'b0);
        do_reset();
        chk("midreset.rd_data", rd_data, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
